mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder_pkg.sv | 30 +++
 rtl/mem_bus_responder_fifo.sv | 63 ++++++
 rtl/mem_bus_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared bus and IO map definitions for the memory bus responder.
// The IO window is selected by address bits 17:16 and holds two byte ports.
package mem_bus_responder_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 8;
    localparam int unsigned RAM_AW = 17;
    localparam int unsigned DEC_AW = 18;

    localparam int unsigned IO_DEC_HI  = 17;
    localparam int unsigned IO_DEC_LO  = 16;
    localparam logic [1:0]  IO_DEC_SEL = 2'b11;

    localparam logic [DEC_AW-1:0] IO_BASE     = 18'h30000;
    localparam logic [DEC_AW-1:0] IO_OFS_DATA = 18'h00000;
    localparam logic [DEC_AW-1:0] IO_OFS_CTRL = 18'h00004;

    localparam logic [DEC_AW-1:0] IO_DATA_ADDR = IO_BASE | IO_OFS_DATA;
    localparam logic [DEC_AW-1:0] IO_CTRL_ADDR = IO_BASE | IO_OFS_CTRL;

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_IO  = 1'b1
    } rd_src_e;

    function automatic logic is_io(input logic [DEC_AW-1:0] addr);
        return addr[IO_DEC_HI:IO_DEC_LO] == IO_DEC_SEL;
    endfunction

endpackage

// File: rtl/mem_bus_responder_fifo.sv
// Power-of-two byte FIFO with a combinational head; a push while full is
// refused based on the count before any same-cycle pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_next_o,
    output logic [7:0]               head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_o       = mem_q[rptr_q];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: routes CPU accesses to RAM or to a small IO block
// (UART tx/rx byte port, program-stop flag, snapshotted cycle counter).
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               mem_en,
    input  logic               mem_wr,
    input  logic [BUS_AW-1:0]  mem_a,
    input  logic [BUS_DW-1:0]  mem_dout,
    output logic [BUS_DW-1:0]  mem_din,
    output logic               io_buffer_full,
    output logic               ram_en,
    output logic               ram_we,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [BUS_DW-1:0]  ram_wdata,
    input  logic [BUS_DW-1:0]  ram_rdata,
    output logic               tx_valid,
    output logic [BUS_DW-1:0]  tx_data,
    input  logic               tx_ready,
    input  logic               rx_valid,
    input  logic [BUS_DW-1:0]  rx_data,
    output logic               rx_ready,
    output logic               program_done,
    output logic               tx_overflow
);

    localparam int unsigned   CW          = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_THRESH = CW'(TX_DEPTH - FULL_MARGIN);

    logic [DEC_AW-1:0] io_ofs;
    logic              unused_addr_hi;
    logic              io_acc, rd_req, wr_req, ctrl_wr;
    logic              tx_push, tx_pop, tx_full;
    logic [CW-1:0]     tx_count, tx_count_next;
    logic [BUS_DW-1:0] io_rbyte;
    logic              rx_pop, snap_load;

    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       snap_q, snap_d;
    rd_src_e           src_q, src_d;
    logic              rd_vld_q, rd_vld_d;
    logic [BUS_DW-1:0] io_q, io_d;
    logic [BUS_DW-1:0] hold_q, hold_d;
    logic              rx_ready_q, rx_ready_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              io_full_q, io_full_d;

    assign io_ofs         = mem_a[DEC_AW-1:0];
    assign unused_addr_hi = ^mem_a[BUS_AW-1:DEC_AW];
    assign io_acc         = is_io(io_ofs);
    assign rd_req         = mem_en & ~mem_wr;
    assign wr_req         = mem_en & mem_wr;

    assign ram_en    = mem_en & ~io_acc;
    assign ram_we    = mem_wr & ~io_acc;
    assign ram_addr  = mem_a[RAM_AW-1:0];
    assign ram_wdata = mem_dout;

    assign tx_push  = wr_req & io_acc & (io_ofs == IO_DATA_ADDR) & (mem_dout != '0);
    assign ctrl_wr  = wr_req & io_acc & (io_ofs == IO_CTRL_ADDR);
    assign tx_valid = (tx_count != '0);
    assign tx_pop   = tx_valid & tx_ready;

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .push_i       (tx_push),
        .din_i        (mem_dout),
        .pop_i        (tx_pop),
        .full_o       (tx_full),
        .count_o      (tx_count),
        .count_next_o (tx_count_next),
        .head_o       (tx_data)
    );

    // Byte 0 of the counter comes live and loads the snapshot; bytes 1-3
    // come from the snapshot so a multi-byte read never tears on a carry.
    always_comb begin
        io_rbyte  = '0;
        rx_pop    = 1'b0;
        snap_load = 1'b0;
        if (rd_req && io_acc) begin
            case (io_ofs)
                IO_DATA_ADDR: begin
                    if (rx_valid) begin
                        io_rbyte = rx_data;
                        rx_pop   = 1'b1;
                    end
                end
                IO_CTRL_ADDR: begin
                    io_rbyte  = cnt_q[7:0];
                    snap_load = 1'b1;
                end
                IO_CTRL_ADDR + 18'd1: io_rbyte = snap_q[15:8];
                IO_CTRL_ADDR + 18'd2: io_rbyte = snap_q[23:16];
                IO_CTRL_ADDR + 18'd3: io_rbyte = snap_q[31:24];
                default:              io_rbyte = '0;
            endcase
        end
    end

    // RAM data arrives a cycle late, so the read mux sits after the registers
    // and a hold copy keeps mem_din stable across non-read cycles.
    assign mem_din = rd_vld_q ? ((src_q == SRC_RAM) ? ram_rdata : io_q) : hold_q;

    always_comb begin
        cnt_d      = cnt_q + 32'd1;
        snap_d     = snap_load ? cnt_q : snap_q;
        rd_vld_d   = rd_req;
        src_d      = src_q;
        io_d       = io_q;
        if (rd_req) begin
            src_d = io_acc ? SRC_IO : SRC_RAM;
            io_d  = io_rbyte;
        end
        hold_d     = mem_din;
        rx_ready_d = rx_pop;
        done_d     = done_q | ctrl_wr;
        ovf_d      = ovf_q | (tx_push & tx_full);
        io_full_d  = (tx_count_next >= FULL_THRESH);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            snap_q     <= '0;
            src_q      <= SRC_RAM;
            rd_vld_q   <= 1'b0;
            io_q       <= '0;
            hold_q     <= '0;
            rx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            io_full_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            src_q      <= src_d;
            rd_vld_q   <= rd_vld_d;
            io_q       <= io_d;
            hold_q     <= hold_d;
            rx_ready_q <= rx_ready_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            io_full_q  <= io_full_d;
        end
    end

    assign rx_ready       = rx_ready_q;
    assign program_done   = done_q;
    assign tx_overflow    = ovf_q;
    assign io_buffer_full = io_full_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a vector table for single accesses
// plus hand-written sequences for FIFO, snapshot and reset behaviour.
module tb_mem_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        mem_en, mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din;
    logic        io_buffer_full;
    logic        ram_en, ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        program_done, tx_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    mem_bus_responder #(
        .TX_DEPTH    (16),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    // RAM: read data one cycle after ram_en; junk after a write so that a
    // non-holding mem_din shows up.
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_rdata         <= ~ram_wdata;
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    // Reference cycle counter: zero in reset, +1 per clock.
    logic [31:0] m_cnt;
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) m_cnt <= 32'd0;
        else        m_cnt <= m_cnt + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [7:0] data);
        mem_en   = 1'b1;
        mem_wr   = wr;
        mem_a    = addr;
        mem_dout = data;
        @(negedge clk_in);
        mem_en = 1'b0;
        mem_wr = 1'b0;
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        exp_ram_en;
        logic [7:0]  exp_din;
        logic        exp_rx_ready;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    logic [31:0] snap;
    int          guard;

    initial begin
        // wr, addr, wdata, rx_valid, rx_data, ram_en, mem_din after, rx_ready after
        vt[0]  = '{1'b1, 32'h0000_0100, 8'hAB, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0};
        vt[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0};
        vt[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vt[4]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1};
        vt[5]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h11, 1'b0, 8'h11, 1'b1};
        vt[7]  = '{1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[8]  = '{1'b1, 32'h0003_0010, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 32'hFFFC_0100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0};
        vt[10] = '{1'b1, 32'h0000_0200, 8'h00, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0};
        vt[11] = '{1'b0, 32'hABC3_0000, 8'h00, 1'b1, 8'h66, 1'b0, 8'h66, 1'b1};
        vt[12] = '{1'b0, 32'h0000_0200, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};

        rst_in   = 1'b1;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_mem_din",   32'(mem_din), 32'h00);
        chk("rst_io_full",   32'(io_buffer_full), 32'h0);
        chk("rst_rx_ready",  32'(rx_ready), 32'h0);
        chk("rst_prog_done", 32'(program_done), 32'h0);
        chk("rst_tx_ovf",    32'(tx_overflow), 32'h0);
        chk("rst_tx_valid",  32'(tx_valid), 32'h0);
        chk("rst_ram_en",    32'(ram_en), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Snapshot across the 0xFF -> 0x100 carry
        guard = 0;
        while (m_cnt != 32'h0000_00FF && guard < 1000) begin
            @(negedge clk_in);
            guard++;
        end
        chk("snap_wait_bound", 32'(guard < 1000), 32'h1);
        snap   = m_cnt;
        mem_en = 1'b1;
        mem_wr = 1'b0;
        mem_a  = 32'h0003_0004;
        @(negedge clk_in); mem_a = 32'h0003_0005; #1;
        chk("snap_b0", 32'(mem_din), 32'(snap[7:0]));
        @(negedge clk_in); mem_a = 32'h0003_0006; #1;
        chk("snap_b1", 32'(mem_din), 32'(snap[15:8]));
        @(negedge clk_in); mem_a = 32'h0003_0007; #1;
        chk("snap_b2", 32'(mem_din), 32'(snap[23:16]));
        @(negedge clk_in); mem_en = 1'b0; #1;
        chk("snap_b3", 32'(mem_din), 32'(snap[31:24]));
        chk("snap_b0_is_ff", 32'(snap[7:0]), 32'hFF);

        // Single-access vector table
        for (int i = 0; i < NV; i++) begin
            rx_valid = vt[i].rxv;
            rx_data  = vt[i].rxd;
            mem_en   = 1'b1;
            mem_wr   = vt[i].wr;
            mem_a    = vt[i].addr;
            mem_dout = vt[i].wdata;
            #1;
            chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vt[i].exp_ram_en));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].exp_ram_en & vt[i].wr));
            if (vt[i].exp_ram_en) begin
                chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].addr[16:0]));
                chk($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vt[i].wdata));
            end
            @(negedge clk_in);
            mem_en   = 1'b0;
            mem_wr   = 1'b0;
            rx_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_mem_din", i), 32'(mem_din), 32'(vt[i].exp_din));
            chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'(vt[i].exp_rx_ready));
            chk($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'h0);
        end
        @(negedge clk_in); #1;
        chk("rx_ready_single_pulse", 32'(rx_ready), 32'h0);

        // 0x41, 0x00, 0x42 with tx stalled: the zero byte is not queued
        tx_ready = 1'b0;
        access(1'b1, 32'h0003_0000, 8'h41);
        access(1'b1, 32'h0003_0000, 8'h00);
        access(1'b1, 32'h0003_0000, 8'h42);
        chk("tx_head_41_valid", 32'(tx_valid), 32'h1);
        chk("tx_head_41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1; #1;
        chk("tx_drain_0", 32'(tx_data), 32'h41);
        @(negedge clk_in); #1;
        chk("tx_drain_1_valid", 32'(tx_valid), 32'h1);
        chk("tx_drain_1", 32'(tx_data), 32'h42);
        @(negedge clk_in); #1;
        chk("tx_drain_empty", 32'(tx_valid), 32'h0);

        // Simultaneous push and pop keeps order and count
        tx_ready = 1'b0;
        access(1'b1, 32'h0003_0000, 8'h61);
        tx_ready = 1'b1;
        access(1'b1, 32'h0003_0000, 8'h62);
        chk("pp_valid", 32'(tx_valid), 32'h1);
        chk("pp_head", 32'(tx_data), 32'h62);
        @(negedge clk_in); #1;
        chk("pp_empty", 32'(tx_valid), 32'h0);
        chk("pp_no_ovf", 32'(tx_overflow), 32'h0);

        // Fill past depth: near-full from 14 entries, overflow on the 17th
        tx_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            access(1'b1, 32'h0003_0000, 8'(k));
            chk($sformatf("fill%0d_io_full", k), 32'(io_buffer_full), 32'(k >= 14));
            chk($sformatf("fill%0d_tx_ovf", k), 32'(tx_overflow), 32'(k >= 17));
        end
        tx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("drain%0d_valid", k), 32'(tx_valid), 32'h1);
            chk($sformatf("drain%0d_data", k), 32'(tx_data), 32'(k));
            @(negedge clk_in);
        end
        #1;
        chk("drain_empty", 32'(tx_valid), 32'h0);
        chk("drain_io_full_clr", 32'(io_buffer_full), 32'h0);
        chk("drain_ovf_sticky", 32'(tx_overflow), 32'h1);
        tx_ready = 1'b0;

        // Program stop then reset during a drain with a read in flight
        access(1'b1, 32'h0003_0004, 8'h01);
        chk("done_set", 32'(program_done), 32'h1);
        chk("done_no_push", 32'(tx_valid), 32'h0);
        access(1'b1, 32'h0003_0000, 8'h21);
        access(1'b1, 32'h0003_0000, 8'h22);
        access(1'b1, 32'h0003_0000, 8'h23);
        chk("done_sticky", 32'(program_done), 32'h1);
        tx_ready = 1'b1;
        @(negedge clk_in); #1;
        chk("mid_drain_head", 32'(tx_data), 32'h22);
        mem_en = 1'b1;
        mem_wr = 1'b0;
        mem_a  = 32'h0000_0100;
        #1;
        rst_in = 1'b1;
        #1;
        chk("arst_prog_done", 32'(program_done), 32'h0);
        chk("arst_tx_ovf",    32'(tx_overflow), 32'h0);
        chk("arst_io_full",   32'(io_buffer_full), 32'h0);
        chk("arst_tx_valid",  32'(tx_valid), 32'h0);
        chk("arst_mem_din",   32'(mem_din), 32'h00);
        chk("arst_rx_ready",  32'(rx_ready), 32'h0);
        mem_en   = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in); #1;
        chk("post_rst_mem_din",   32'(mem_din), 32'h00);
        chk("post_rst_prog_done", 32'(program_done), 32'h0);
        chk("post_rst_tx_valid",  32'(tx_valid), 32'h0);
        access(1'b0, 32'h0000_0100, 8'h00);
        chk("post_rst_first_read", 32'(mem_din), 32'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
